// File: rtl/satd_row_feeder_if.sv
// Pixel-stream and packed-row handshake bundle for the SATD row feeder.
// slave is the feeder side; master is the producer/consumer side.
interface satd_row_feeder_if #(
  parameter int PIX_W    = 8,
  parameter int ROW_PIX  = 8,
  parameter int BLK_ROWS = 8
);
  localparam int W  = PIX_W * ROW_PIX;
  localparam int RW = (BLK_ROWS > 1) ? $clog2(BLK_ROWS) : 1;

  logic [PIX_W-1:0] org_pix;
  logic             org_valid;
  logic             org_ready;
  logic [PIX_W-1:0] cur_pix;
  logic             cur_valid;
  logic             cur_ready;
  logic [W-1:0]     ORG;
  logic [W-1:0]     CUR;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [RW-1:0]    row_idx;

  modport slave (
    input  org_pix, org_valid, cur_pix, cur_valid, out_ready,
    output org_ready, cur_ready, ORG, CUR, out_valid, out_last, row_idx
  );

  modport master (
    output org_pix, org_valid, cur_pix, cur_valid, out_ready,
    input  org_ready, cur_ready, ORG, CUR, out_valid, out_last, row_idx
  );
endinterface

// File: rtl/satd_row_feeder.sv
// Packs org/cur pixel streams into aligned 64-bit row pairs for SATD.
// Each stream: beat packer + small row FIFO; pair emitted when both exist.
module satd_row_feeder #(
  parameter int PIX_W      = 8,
  parameter int ROW_PIX    = 8,
  parameter int BLK_ROWS   = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  satd_row_feeder_if.slave bus
);
  localparam int W  = PIX_W * ROW_PIX;
  localparam int CW = (ROW_PIX > 1) ? $clog2(ROW_PIX) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam int RW = (BLK_ROWS > 1) ? $clog2(BLK_ROWS) : 1;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic pop;

  for (genvar s = 0; s < 2; s++) begin : g_st
    logic [PIX_W-1:0] pix;
    logic             vld;
    logic             rdy;
    logic             acc;
    logic             push;
    logic             ne;
    logic [CW-1:0]    cnt;
    logic [W-1:0]     word;
    logic [W-1:0]     word_n;
    logic [W-1:0]     head;
    logic [W-1:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [NW-1:0]    fcnt;

    assign pix  = (s == 0) ? bus.org_pix : bus.cur_pix;
    assign vld  = (s == 0) ? bus.org_valid : bus.cur_valid;
    // Only the closing beat needs FIFO room; earlier beats sit in the packer.
    assign rdy  = (cnt != CW'(ROW_PIX - 1)) || (fcnt != NW'(FIFO_DEPTH));
    assign acc  = vld && rdy;
    assign push = acc && (cnt == CW'(ROW_PIX - 1));
    assign ne   = (fcnt != '0);
    assign head = mem[rp];

    always_comb begin
      word_n = word;
      word_n[PIX_W*cnt +: PIX_W] = pix;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt  <= '0;
        word <= '0;
        wp   <= '0;
        rp   <= '0;
        fcnt <= '0;
        for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
        cnt  <= '0;
        wp   <= '0;
        rp   <= '0;
        fcnt <= '0;
      end else begin
        if (acc) begin
          word <= word_n;
          cnt  <= push ? '0 : cnt + 1'b1;
        end
        if (push) begin
          mem[wp] <= word_n;
          wp      <= nxt(wp);
        end
        if (pop) rp <= nxt(rp);
        case ({push, pop})
          2'b10:   fcnt <= fcnt + 1'b1;
          2'b01:   fcnt <= fcnt - 1'b1;
          default: fcnt <= fcnt;
        endcase
      end
    end
  end

  logic [RW-1:0] row_q;

  assign bus.org_ready = g_st[0].rdy;
  assign bus.cur_ready = g_st[1].rdy;
  assign bus.out_valid = g_st[0].ne && g_st[1].ne;
  assign bus.ORG       = g_st[0].head;
  assign bus.CUR       = g_st[1].head;
  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.row_idx   = row_q;
  assign bus.out_last  = (row_q == RW'(BLK_ROWS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q <= '0;
    end else if (flush) begin
      row_q <= '0;
    end else if (pop) begin
      row_q <= (row_q == RW'(BLK_ROWS - 1)) ? '0 : row_q + 1'b1;
    end
  end
endmodule
